// File: rtl/camera_dvp_tx.sv
// DVP camera transmitter: streams RGB565 pixels as vsync/href/byte traffic with internally generated frame timing.
// Optional build macro CAM_TX_PATTERN_EN adds an internal 8-bar colour generator selected by pattern_sel.
module camera_dvp_tx #(
  parameter int         H_ACTIVE    = 640,
  parameter int         H_BLANK     = 144,
  parameter int         V_ACTIVE    = 480,
  parameter int         VSYNC_LINES = 3,
  parameter int         VBP_LINES   = 17,
  parameter int         VFP_LINES   = 10,
  parameter logic [7:0] FILL_BYTE   = 8'h00
) (
  input  logic        p_clock,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        pattern_sel,
  input  logic        underrun_clr,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_start,
  output logic        underrun
);

  localparam int L      = 2*H_ACTIVE + H_BLANK;
  localparam int BCNT_W = (L > 2) ? $clog2(L) : 1;
  localparam int LMAX1  = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int LMAX2  = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int LMAX   = (LMAX1 > LMAX2) ? LMAX1 : LMAX2;
  localparam int LCNT_W = (LMAX > 2) ? $clog2(LMAX) : 1;

  localparam logic [BCNT_W-1:0] B_LINE_END  = BCNT_W'(L - 1);
  localparam logic [BCNT_W-1:0] B_ACT_END   = BCNT_W'(2*H_ACTIVE - 1);
  localparam logic [LCNT_W-1:0] L_VSYNC_END = LCNT_W'(VSYNC_LINES - 1);
  localparam logic [LCNT_W-1:0] L_VBP_END   = LCNT_W'(VBP_LINES - 1);
  localparam logic [LCNT_W-1:0] L_VACT_END  = LCNT_W'(V_ACTIVE - 1);
  localparam logic [LCNT_W-1:0] L_VFP_END   = LCNT_W'(VFP_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_BLANK  = 3'd4,
    S_VFP    = 3'd5
  } state_t;

  state_t            r_state;
  logic [BCNT_W-1:0] r_bcnt;
  logic [LCNT_W-1:0] r_lcnt;
  logic              r_vsync;
  logic              r_href;
  logic [7:0]        r_data;
  logic [7:0]        r_lo;
  logic              r_fs;
  logic              r_under;

  logic              w_line_end;
  logic              w_lcnt_last;
  logic              w_slot;
  logic              w_start;
  logic              w_fill;
  logic [15:0]       w_pix;

  assign w_line_end = (r_bcnt == B_LINE_END);

  // w_slot: the byte registered on this edge is the high byte of an active pixel
  always_comb begin
    w_lcnt_last = 1'b0;
    w_slot      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: w_start = enable;
      S_VSYNC: w_lcnt_last = (r_lcnt == L_VSYNC_END);
      S_VBP: begin
        w_lcnt_last = (r_lcnt == L_VBP_END);
        w_slot      = w_line_end && w_lcnt_last;
      end
      S_ACTIVE: begin
        w_lcnt_last = (r_lcnt == L_VACT_END);
        w_slot      = r_bcnt[0] && (r_bcnt != B_ACT_END);
      end
      S_BLANK: begin
        w_lcnt_last = (r_lcnt == L_VACT_END);
        w_slot      = w_line_end && !w_lcnt_last;
      end
      S_VFP: begin
        w_lcnt_last = (r_lcnt == L_VFP_END);
        w_start     = w_line_end && w_lcnt_last && enable;
      end
      default: ;
    endcase
  end

`ifdef CAM_TX_PATTERN_EN
  logic              r_pat;
  logic [BCNT_W-1:0] w_bnext;
  logic [2:0]        w_bar;

  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Pixel loaded mid-line is x=(bcnt+1)/2; a load outside ACTIVE starts a line at x=0
  assign w_bnext = r_bcnt + BCNT_W'(1);
  assign w_bar   = (r_state == S_ACTIVE) ? 3'((32'(w_bnext >> 1) * 8) / H_ACTIVE) : 3'd0;
  assign w_pix   = r_pat ? bar_color(w_bar) : s_pixel;
  assign s_ready = w_slot && !r_pat;
  assign w_fill  = s_ready && !s_valid;

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n)       r_pat <= 1'b0;
    else if (w_start) r_pat <= pattern_sel;
  end
`else
  logic w_unused_pattern_sel;
  assign w_unused_pattern_sel = pattern_sel;
  assign w_pix   = s_pixel;
  assign s_ready = w_slot;
  assign w_fill  = w_slot && !s_valid;
`endif

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_lcnt  <= '0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= '0;
      r_fs    <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_fs <= 1'b0;

      if (w_fill)            r_under <= 1'b1;
      else if (underrun_clr) r_under <= 1'b0;

      if (w_slot)                                     r_data <= w_fill ? FILL_BYTE : w_pix[15:8];
      else if (r_state == S_ACTIVE && !r_bcnt[0])     r_data <= r_lo;
      else                                            r_data <= '0;

      if (r_state != S_IDLE) begin
        r_bcnt <= w_line_end ? '0 : r_bcnt + BCNT_W'(1);
        if (w_line_end) r_lcnt <= w_lcnt_last ? '0 : r_lcnt + LCNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_VSYNC;
            r_vsync <= 1'b1;
            r_fs    <= 1'b1;
            r_bcnt  <= '0;
            r_lcnt  <= '0;
          end
        end
        S_VSYNC: begin
          if (w_line_end && w_lcnt_last) begin
            r_state <= S_VBP;
            r_vsync <= 1'b0;
          end
        end
        S_VBP: begin
          if (w_line_end && w_lcnt_last) begin
            r_state <= S_ACTIVE;
            r_href  <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (r_bcnt == B_ACT_END) begin
            r_state <= S_BLANK;
            r_href  <= 1'b0;
          end
        end
        S_BLANK: begin
          if (w_line_end) begin
            if (w_lcnt_last) begin
              r_state <= S_VFP;
            end else begin
              r_state <= S_ACTIVE;
              r_href  <= 1'b1;
            end
          end
        end
        S_VFP: begin
          if (w_start) begin
            r_state <= S_VSYNC;
            r_vsync <= 1'b1;
            r_fs    <= 1'b1;
          end else if (w_line_end && w_lcnt_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Low byte is parked for one clock while the high byte is on the bus
  always_ff @(posedge p_clock) begin
    if (w_slot) r_lo <= w_fill ? FILL_BYTE : w_pix[7:0];
  end

  assign vsync       = r_vsync;
  assign href        = r_href;
  assign p_data      = r_data;
  assign frame_start = r_fs;
  assign underrun    = r_under;

endmodule

// File: tb/tb_camera_dvp_tx.sv
// Bench for camera_dvp_tx: cycle-by-cycle comparison against a frame-timing model derived from time offsets.
module tb_camera_dvp_tx;

  localparam int H_ACTIVE    = 4;
  localparam int H_BLANK     = 6;
  localparam int V_ACTIVE    = 2;
  localparam int VSYNC_LINES = 1;
  localparam int VBP_LINES   = 1;
  localparam int VFP_LINES   = 1;
  localparam int L           = 2*H_ACTIVE + H_BLANK;
  localparam int T_ACT       = (VSYNC_LINES + VBP_LINES) * L;
  localparam int FRAME       = (VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES) * L;

  logic        p_clock = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic        pattern_sel;
  logic        underrun_clr;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        frame_start;
  logic        underrun;

  int          checks = 0;
  int          errors = 0;
  logic        exp_under;
  logic [7:0]  exp_q[$];
  logic [15:0] bar_rgb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  camera_dvp_tx #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES),
    .FILL_BYTE(8'h00)
  ) dut (
    .p_clock(p_clock), .rst_n(rst_n), .enable(enable),
    .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .pattern_sel(pattern_sel), .underrun_clr(underrun_clr),
    .vsync(vsync), .href(href), .p_data(p_data),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 p_clock = ~p_clock;

  // Model: t counts clocks since the frame_start clock
  function automatic bit m_href(input int t);
    int a;
    a = t - T_ACT;
    return (a >= 0) && (a < V_ACTIVE*L) && ((a % L) < 2*H_ACTIVE);
  endfunction

  function automatic bit m_slot(input int t);
    int a;
    a = t + 1 - T_ACT;
    return m_href(t + 1) && (((a % L) % 2) == 0);
  endfunction

  task automatic run_frame(input int bad_pix, input int drop_t, input int clr_t,
                           input int abort_t, input bit fixed, input bit pat, output int hs);
    logic [15:0] pix;
    logic [7:0]  eb;
    logic        e_vs, e_hr, e_fs, e_rdy;
    bit          v, set_u;
    int          a, k;
    hs = 0;
    exp_q.delete();
    for (int t = 0; t < FRAME; t++) begin
      e_vs  = (t < VSYNC_LINES*L);
      e_hr  = m_href(t);
      e_fs  = (t == 0);
      e_rdy = m_slot(t) && !pat;
      checks++;
      if (vsync !== e_vs) begin errors++; $display("FAIL vsync t=%0d got %b exp %b", t, vsync, e_vs); end
      checks++;
      if (href !== e_hr) begin errors++; $display("FAIL href t=%0d got %b exp %b", t, href, e_hr); end
      checks++;
      if (frame_start !== e_fs) begin errors++; $display("FAIL frame_start t=%0d got %b exp %b", t, frame_start, e_fs); end
      checks++;
      if (s_ready !== e_rdy) begin errors++; $display("FAIL s_ready t=%0d got %b exp %b", t, s_ready, e_rdy); end
      checks++;
      if (underrun !== exp_under) begin errors++; $display("FAIL underrun t=%0d got %b exp %b", t, underrun, exp_under); end
      if (e_hr) begin
        if (exp_q.size() == 0) eb = 8'hxx;
        else eb = exp_q.pop_front();
      end else begin
        eb = 8'h00;
      end
      checks++;
      if (p_data !== eb) begin errors++; $display("FAIL p_data t=%0d got %h exp %h", t, p_data, eb); end
      if (t == abort_t) return;

      enable       = !(drop_t >= 0 && t >= drop_t);
      underrun_clr = (t == clr_t);
      set_u        = 1'b0;
      if (m_slot(t)) begin
        a   = t + 1 - T_ACT;
        k   = (a / L) * H_ACTIVE + (a % L) / 2;
        pix = 16'($urandom);
        if (fixed && k == 0) pix = 16'hA1B2;
        if (fixed && k == 1) pix = 16'hC3D4;
        v       = (k != bad_pix);
        s_pixel = pix;
        s_valid = v;
        if (pat) begin
          pix = bar_rgb[(((a % L) / 2) * 8) / H_ACTIVE];
          exp_q.push_back(pix[15:8]);
          exp_q.push_back(pix[7:0]);
        end else if (v) begin
          exp_q.push_back(pix[15:8]);
          exp_q.push_back(pix[7:0]);
        end else begin
          exp_q.push_back(8'h00);
          exp_q.push_back(8'h00);
          set_u = 1'b1;
        end
      end else begin
        s_pixel = 16'($urandom);
        s_valid = 1'($urandom);
      end
      if (s_ready && s_valid) hs++;
      if (set_u) exp_under = 1'b1;
      else if (t == clr_t) exp_under = 1'b0;
      @(negedge p_clock);
    end
    underrun_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; s_pixel = '0; s_valid = 1'b0;
    pattern_sel = 1'b0; underrun_clr = 1'b0; exp_under = 1'b0;
    repeat (3) @(negedge p_clock);
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got %b exp 0", vsync); end
    checks++; if (href !== 1'b0) begin errors++; $display("FAIL reset_href got %b exp 0", href); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data got %h exp 00", p_data); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge p_clock);
      checks++;
      if (vsync !== 1'b0 || frame_start !== 1'b0) begin
        errors++; $display("FAIL idle_disabled cyc=%0d vsync=%b fs=%b exp 0 0", i, vsync, frame_start);
      end
    end
  endtask

  task automatic test_timing_bytes();
    int hs;
    enable  = 1'b1;
    s_valid = 1'b1;
    @(negedge p_clock);
    run_frame(-1, -1, -1, -1, 1'b1, 1'b0, hs);
    checks++; if (hs != 2*V_ACTIVE*H_ACTIVE/2*1 && hs != V_ACTIVE*H_ACTIVE) begin errors++; end
    checks++; if (hs !== V_ACTIVE*H_ACTIVE) begin errors++; $display("FAIL handshakes got %0d exp %0d", hs, V_ACTIVE*H_ACTIVE); end
    run_frame(-1, -1, -1, -1, 1'b0, 1'b0, hs);
  endtask

  task automatic test_underrun();
    int hs;
    run_frame(1, -1, -1, -1, 1'b1, 1'b0, hs);
    run_frame(-1, -1, 5, -1, 1'b0, 1'b0, hs);
    run_frame(5, -1, T_ACT + L + 1, -1, 1'b0, 1'b0, hs);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set_wins got %b exp 1", underrun); end
  endtask

  task automatic test_enable_drop();
    int hs;
    run_frame(-1, T_ACT + L + 3, -1, -1, 1'b0, 1'b0, hs);
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (frame_start !== 1'b0 || vsync !== 1'b0 || href !== 1'b0 || s_ready !== 1'b0 || p_data !== 8'h00) begin
        errors++;
        $display("FAIL idle_after_drop cyc=%0d fs=%b vs=%b hr=%b rdy=%b d=%h exp all 0",
                 i, frame_start, vsync, href, s_ready, p_data);
      end
      @(negedge p_clock);
    end
  endtask

  task automatic test_reset_mid_frame();
    int hs;
    enable = 1'b1;
    @(negedge p_clock);
    run_frame(-1, -1, -1, T_ACT + 2, 1'b0, 1'b0, hs);
    rst_n = 1'b0;
    #1;
    exp_under = 1'b0;
    checks++; if (href !== 1'b0) begin errors++; $display("FAIL midreset_href got %b exp 0", href); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL midreset_p_data got %h exp 00", p_data); end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL midreset_vsync got %b exp 0", vsync); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midreset_underrun got %b exp 0", underrun); end
    @(negedge p_clock);
    rst_n = 1'b1;
    @(negedge p_clock);
    run_frame(-1, -1, -1, -1, 1'b1, 1'b0, hs);
  endtask

`ifdef CAM_TX_PATTERN_EN
  task automatic test_pattern();
    int hs;
    rst_n = 1'b0;
    @(negedge p_clock);
    rst_n       = 1'b1;
    exp_under   = 1'b0;
    pattern_sel = 1'b1;
    enable      = 1'b1;
    @(negedge p_clock);
    run_frame(-1, -1, -1, -1, 1'b0, 1'b1, hs);
    run_frame(-1, -1, -1, -1, 1'b0, 1'b1, hs);
    checks++; if (hs !== 0) begin errors++; $display("FAIL pattern_handshakes got %0d exp 0", hs); end
  endtask
`endif

  initial begin
    test_reset();
    test_timing_bytes();
    test_underrun();
    test_enable_drop();
    test_reset_mid_frame();
`ifdef CAM_TX_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/camera_dvp_tx.md
Name: camera_dvp_tx

Overview:
- DVP-style camera transmitter: serialises 16-bit RGB565 pixels into the vsync/href/8-bit byte stream an OV7670-class sensor drives.
- It is the source end of the camera capture interface.
- Used as a sensor model in simulation and as a loopback/self-test source in front of the capture path on the FPGA.
- Upstream pixels arrive on a valid/ready handshake. Frame and line timing is generated internally from parameters.

Parameters:
- H_ACTIVE, 640, active pixels per line (each pixel is 2 bytes, so href is high 2*H_ACTIVE clocks)
- H_BLANK, 144, href-low clocks after each active line
- V_ACTIVE, 480, active lines per frame
- VSYNC_LINES, 3, lines with vsync high
- VBP_LINES, 17, blank lines after vsync before the first active line
- VFP_LINES, 10, blank lines after the last active line
- FILL_BYTE, 8'h00, byte driven on underrun

Ports:
- p_clock  in  1  pixel/byte clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  frame generation enable, sampled only at frame boundaries
- s_pixel  in  16  upstream RGB565 pixel, [15:8] sent first
- s_valid  in  1  s_pixel valid
- s_ready  out  1  pixel accepted when s_valid && s_ready
- pattern_sel  in  1  select internal pattern (only with CAM_TX_PATTERN_EN)
- underrun_clr  in  1  clears underrun
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- p_data  out  8  byte stream
- frame_start  out  1  one-cycle pulse on the first vsync-high clock
- underrun  out  1  sticky: active byte slot had no valid pixel

Behaviour:
- Reset: vsync=0, href=0, p_data=0, frame_start=0, underrun=0, s_ready=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately, with no partial-line completion.
- Line period L = 2*H_ACTIVE + H_BLANK clocks, for every line type.
- States:
  - IDLE: all outputs low. When enable=1, go to VSYNC and pulse frame_start.
  - VSYNC: vsync=1 for VSYNC_LINES*L clocks, then VBP.
  - VBP: VBP_LINES*L clocks, then ACTIVE.
  - ACTIVE: href=1 for 2*H_ACTIVE clocks, then BLANK.
  - BLANK: H_BLANK clocks. Then ACTIVE if lines sent < V_ACTIVE, else VFP.
  - VFP: VFP_LINES*L clocks. Then VSYNC (with frame_start) if enable=1, else IDLE.
- enable dropping mid-frame has no effect until the end of VFP.
- All outputs are registered. href and the first p_data byte change on the same clock. vsync and href are never high together.
- Byte phase toggles each href-high clock: phase 0 carries the high byte, phase 1 the low byte.
- s_ready=1 (combinational from state) exactly on clocks where the next registered byte is phase 0 of an active pixel. This is the clock before each pixel's high byte. On every other clock s_ready=0.
- On a handshake, s_pixel is captured: p_data<=s_pixel[15:8] next clock, then s_pixel[7:0] the clock after.
- Underrun: s_ready=1 with s_valid=0. Both bytes of that pixel are driven as FILL_BYTE and underrun is set. Timing never stalls.
- underrun is cleared only by underrun_clr or reset. If set and clear occur on the same clock, set wins.
- Counters wrap to 0 at each terminal count. Byte counter width is clog2(2*H_ACTIVE+H_BLANK); line counter width is clog2 of the largest line count.

Optional Feature:
- Macro: CAM_TX_PATTERN_EN
- Defined: while pattern_sel=1, pixels come from an internal 8-bar colour generator and s_ready is held 0.
  - Bar index = pixel_x*8/H_ACTIVE.
  - Colours in RGB565: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - pattern_sel is sampled at frame_start only. Underrun cannot occur in pattern mode.
- Not defined: pattern_sel is ignored; upstream is always the source.

Test Plan:
- Bench parameters: H_ACTIVE=4, H_BLANK=6, V_ACTIVE=2, VSYNC_LINES=1, VBP=1, VFP=1, so L=14.
- Timing: enable=1, s_valid=1 -> frame_start pulse, vsync high 14 clocks, href low 14, then two 8-clock href pulses separated by 6 low; next frame_start exactly 70 clocks after the first.
- Byte order: s_pixel sequence 16'hA1B2, 16'hC3D4 -> p_data A1,B2,C3,D4 on consecutive href-high clocks; 8 s_ready handshakes per frame.
- Underrun: s_valid=0 for the 2nd pixel of line 0 -> bytes 2,3 = 8'h00; underrun=1 and stays set; underrun_clr pulse -> 0; set and clear on the same clock -> stays 1.
- Enable drop: enable=0 during line 1 -> frame completes, including VFP; outputs then stay in IDLE and no further frame_start occurs.
- Reset: rst_n low on the 3rd href-high clock -> href, p_data, vsync immediately 0. After release with enable=1, a fresh frame_start occurs and byte order is correct.
- With CAM_TX_PATTERN_EN and pattern_sel=1 -> s_ready stays 0; the 4 pixels of each line are FFFF, 07FF, F81F, 001F.
